// File: rtl/serial_adder.sv
// Bit-serial adder (optional subtract with SERIAL_SUB_EN): one full-adder cell plus a carry flop, LSB first.
// Latency WIDTH edges after the accepting edge; start is ignored while busy, and results hold until the next completion.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sha_q, sha_d;
    logic [WIDTH-1:0] shb_q, shb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             done_q, done_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             sub_i;
    logic             bit_s;
    logic             bit_c;
    logic             last_bit;
    logic             accept;

`ifdef SERIAL_SUB_EN
    assign sub_i = sub;
`else
    assign sub_i = 1'b0;
`endif

    assign bit_s    = sha_q[0] ^ shb_q[0] ^ carry_q;
    assign bit_c    = (sha_q[0] & shb_q[0]) | (sha_q[0] & carry_q) | (shb_q[0] & carry_q);
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    assign accept   = (state_q == IDLE) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sha_q   <= '0;
            shb_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sha_d   = sha_q;
        shb_d   = shb_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        done_d  = 1'b0;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (accept) begin
            // Subtraction is a + ~b + 1: invert B and preload the carry.
            sha_d   = a;
            shb_d   = sub_i ? ~b : b;
            carry_d = sub_i;
            res_d   = '0;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            sha_d   = sha_q >> 1;
            shb_d   = shb_q >> 1;
            res_d   = {bit_s, res_q[WIDTH-1:1]};
            carry_d = bit_c;
            cnt_d   = cnt_q + CNT_W'(1);
            if (last_bit) begin
                // carry_q is the carry into the MSB on this step.
                sum_d  = {bit_s, res_q[WIDTH-1:1]};
                cout_d = bit_c;
                ovf_d  = carry_q ^ bit_c;
                done_d = 1'b1;
                cnt_d  = '0;
            end
        end
    end

    always_comb begin
        busy = (state_q == RUN);
        done = done_q;
        sum  = sum_q;
        cout = cout_q;
        ovf  = ovf_q;
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 against an arithmetic reference, plus WIDTH=2 and WIDTH=32 instances.
module tb_serial_adder;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [W-1:0] a, b;
    logic sub;
    logic busy, done, cout, ovf;
    logic [W-1:0] sum;

    logic start2;
    logic [1:0] a2, b2, sum2;
    logic busy2, done2, cout2, ovf2;

    logic start32;
    logic [31:0] a32, b32, sum32;
    logic busy32, done32, cout32, ovf32;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
`ifdef SERIAL_SUB_EN
        .sub(sub),
`endif
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
`ifdef SERIAL_SUB_EN
        .sub(1'b0),
`endif
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
    );

    serial_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32),
`ifdef SERIAL_SUB_EN
        .sub(1'b0),
`endif
        .busy(busy32), .done(done32), .sum(sum32), .cout(cout32), .ovf(ovf32)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference result as {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic [W:0] r;
        logic c, v;
        if (s) begin
            r = {1'b0, x} - {1'b0, y};
            c = (x >= y);
            v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        end else begin
            r = {1'b0, x} + {1'b0, y};
            c = r[W];
            v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
        end
        return {v, c, r[W-1:0]};
    endfunction

    logic m_busy = 1'b0, m_done = 1'b0, m_cout = 1'b0, m_ovf = 1'b0;
    logic [W-1:0] m_sum = '0;
    logic [W+1:0] pend = '0;
    int left = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
            left   <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                left <= left - 1;
                if (left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    {m_ovf, m_cout, m_sum} <= pend;
                end
            end else if (start) begin
                pend   <= ref_op(a, b, sub);
                m_busy <= 1'b1;
                left   <= W;
            end
        end
    end

    always @(negedge clk) begin
        check("m_busy", busy, m_busy);
        check("m_done", done, m_done);
        check("m_sum",  sum,  m_sum);
        check("m_cout", cout, m_cout);
        check("m_ovf",  ovf,  m_ovf);
    end

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 4 * W + 10) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                          input logic [W-1:0] es, input logic ec, input logic eo, input string nm);
        int n;
        @(negedge clk);
        a = ta; b = tb_; sub = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~ta; b = ~tb_;
        check({nm, "_busy"}, busy, 1);
        wait_done(n);
        check({nm, "_lat"}, n, W);
        check({nm, "_sum"}, sum, es);
        check({nm, "_cout"}, cout, ec);
        check({nm, "_ovf"}, ovf, eo);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0;
        start32 = 1'b0; a32 = '0; b32 = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        rst = 1'b0;

        run_op(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1, "add_5a_33");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01");

        // Held start: must be taken only on the edge after done.
        @(negedge clk);
        a = 8'h12; b = 8'h34; start = 1'b1;
        @(negedge clk);
        a = 8'hFF; b = 8'hFF;
        check("held_busy", busy, 1);
        check("held_sum_hold", sum, 8'h80);
        wait_done(n);
        check("held_lat1", n, W);
        check("held_sum1", sum, 8'h46);
        check("held_cout1", cout, 0);
        @(negedge clk);
        check("held_accept", busy, 1);
        check("held_done_low", done, 0);
        start = 1'b0;
        wait_done(n);
        check("held_lat2", n, W);
        check("held_sum2", sum, 8'hFE);
        check("held_cout2", cout, 1);
        check("held_ovf2", ovf, 0);

        // Asynchronous reset after three RUN edges.
        @(negedge clk);
        a = 8'h55; b = 8'h22; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_sum", sum, 0);
        check("arst_cout", cout, 0);
        check("arst_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            check("arst_no_done", done, 0);
        end
        run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, "post_rst");

`ifdef SERIAL_SUB_EN
        run_op(8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0, "sub_10_01");
        run_op(8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, "sub_00_01");
        run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01");
`endif

        @(negedge clk);
        a2 = 2'h3; b2 = 2'h1; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("w2_lat", n, 2);
        check("w2_sum", sum2, 0);
        check("w2_cout", cout2, 1);
        check("w2_ovf", ovf2, 0);

        @(negedge clk);
        a32 = 32'hFFFF_FFFF; b32 = 32'h1; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        n = 0;
        while (!done32 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("w32_lat", n, 32);
        check("w32_sum", sum32, 0);
        check("w32_cout", cout32, 1);
        check("w32_ovf", ovf32, 0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
